// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

    // Request/response tracking: none outstanding, one outstanding, one outstanding but killed.
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } e_fetch_state;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, posedge update.
module fetch_btb
    import fetch_unit_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        lookup_hit,
    output logic [31:0] lookup_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 32 - 2 - IDX_W;

    logic             valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [31:0]      target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] lookup_idx, upd_idx;
    logic [TAG_W-1:0] lookup_tag, upd_tag;
    logic             unused_low_bits;

    assign lookup_idx      = lookup_pc[2 +: IDX_W];
    assign lookup_tag      = lookup_pc[31 -: TAG_W];
    assign upd_idx         = upd_pc[2 +: IDX_W];
    assign upd_tag         = upd_pc[31 -: TAG_W];
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
    always_comb begin
        lookup_hit    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        lookup_target = target_q[lookup_idx];
    end

    // Valid bits: set on taken update, cleared on not-taken update with matching tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
            end else if (tag_q[upd_idx] == upd_tag) begin
                valid_q[upd_idx] <= 1'b0;
            end
        end
    end

    // Tag and target payload; meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= align_word(upd_target);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, imem request/response handling, skid buffer, decode outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        fetch_stall,
    input  logic        exec_redirect_valid,
    input  logic [31:0] exec_redirect_pc,
    input  logic        btb_upd_valid,
    input  logic [31:0] btb_upd_pc,
    input  logic [31:0] btb_upd_target,
    input  logic        btb_upd_taken,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pred_next_pc,
    output logic [31:0] fetch_inst
);

    e_fetch_state state_q, state_d;
    logic [31:0]  pc_q, inflight_pc_q, inflight_pred_q;
    logic         skid_valid_q;
    logic [31:0]  skid_pc_q, skid_pred_q, skid_inst_q;
    logic         btb_hit;
    logic [31:0]  btb_target, pred_pc;
    logic         resp_in_wait, accept;

    fetch_btb #(
        .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (pc_q),
        .lookup_hit   (btb_hit),
        .lookup_target(btb_target),
        .upd_valid    (btb_upd_valid),
        .upd_pc       (btb_upd_pc),
        .upd_target   (btb_upd_target),
        .upd_taken    (btb_upd_taken)
    );

    assign imem_req_addr = pc_q;
    assign pred_pc       = btb_hit ? btb_target : pc_q + 32'd4;
    assign resp_in_wait  = imem_resp_valid && (state_q == S_WAIT);

    // A new request may issue when nothing is outstanding or the outstanding one returns now.
    always_comb begin
        imem_req_valid = ((state_q == S_REQ) || resp_in_wait) && !fetch_stall &&
                         !skid_valid_q && !exec_redirect_valid;
        accept         = imem_req_valid && imem_req_ready;
    end

    // Next-state: redirect kills an outstanding request unless its response lands this cycle.
    always_comb begin
        state_d = state_q;
        if (exec_redirect_valid) begin
            unique case (state_q)
                S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DROP;
                S_DROP:  state_d = imem_resp_valid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ:   state_d = accept ? S_WAIT : S_REQ;
                S_WAIT:  state_d = imem_resp_valid ? (accept ? S_WAIT : S_REQ) : S_WAIT;
                S_DROP:  state_d = imem_resp_valid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    // PC, FSM and in-flight request bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_REQ;
            pc_q            <= align_word(RESET_PC);
            inflight_pc_q   <= 32'h0;
            inflight_pred_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (exec_redirect_valid) begin
                pc_q <= align_word(exec_redirect_pc);
            end else if (accept) begin
                pc_q            <= pred_pc;
                inflight_pc_q   <= pc_q;
                inflight_pred_q <= pred_pc;
            end
        end
    end

    // Decode-facing output slot and the one-entry skid that catches a response during stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid        <= 1'b0;
            fetch_pc           <= 32'h0;
            fetch_pred_next_pc <= 32'h0;
            fetch_inst         <= INST_NOP;
            skid_valid_q       <= 1'b0;
            skid_pc_q          <= 32'h0;
            skid_pred_q        <= 32'h0;
            skid_inst_q        <= INST_NOP;
        end else if (exec_redirect_valid) begin
            fetch_valid  <= 1'b0;
            fetch_inst   <= INST_NOP;
            skid_valid_q <= 1'b0;
        end else if (fetch_stall) begin
            if (resp_in_wait) begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= inflight_pc_q;
                skid_pred_q  <= inflight_pred_q;
                skid_inst_q  <= imem_resp_data;
            end
        end else if (skid_valid_q) begin
            fetch_valid        <= 1'b1;
            fetch_pc           <= skid_pc_q;
            fetch_pred_next_pc <= skid_pred_q;
            fetch_inst         <= skid_inst_q;
            skid_valid_q       <= 1'b0;
        end else if (resp_in_wait) begin
            fetch_valid        <= 1'b1;
            fetch_pc           <= inflight_pc_q;
            fetch_pred_next_pc <= inflight_pred_q;
            fetch_inst         <= imem_resp_data;
        end else begin
            fetch_valid <= 1'b0;
            fetch_inst  <= INST_NOP;
        end
    end

endmodule
